// File: rtl/timing_loop_nco.sv
// PI loop filter plus phase-accumulator NCO closing the symbol-timing loop.
// Optional freeze input enabled by TIMING_LOOP_FREEZE_EN.
module timing_loop_nco #(
  parameter int SamplesPerSymbol = 4,
  parameter int ErrorLengthBits  = 25,
  parameter int PhaseLengthBits  = 32,
  parameter int KpShift          = 8,
  parameter int KiShift          = 16
) (
  input  logic                              clk,
  input  logic                              rst,
`ifdef TIMING_LOOP_FREEZE_EN
  input  logic                              freeze,
`endif
  input  logic signed [ErrorLengthBits-1:0] error,
  input  logic                              error_valid,
  output logic                              error_ready,
  input  logic                              sample_strobe,
  output logic                              trigger,
  output logic signed [PhaseLengthBits-1:0] control,
  output logic                              control_valid
);

  localparam int P = PhaseLengthBits;
  localparam int E = ErrorLengthBits;
  localparam int NomLsb = P - $clog2(SamplesPerSymbol);

  localparam logic [P-1:0] NOM =
    {{(P-1){1'b0}}, 1'b1} << NomLsb;
  localparam logic [P:0] HALF = {2'b00, NOM[P-1:1]};
  localparam logic signed [P:0] LIM_HI_W =
    $signed(HALF - {{P{1'b0}}, 1'b1});
  localparam logic signed [P:0] LIM_LO_W = -$signed(HALF);
  localparam logic signed [P-1:0] LIM_HI = LIM_HI_W[P-1:0];
  localparam logic signed [P-1:0] LIM_LO = LIM_LO_W[P-1:0];

  typedef enum logic [1:0] {
    IDLE,
    SCALE,
    UPDATE
  } state_e;

  state_e state_q, state_d;

  logic signed [E-1:0] err_q, err_d;
  logic signed [P-1:0] prop_q, prop_d;
  logic signed [P-1:0] inc_q, inc_d;
  logic signed [P-1:0] integ_q, integ_d;
  logic signed [P-1:0] ctrl_q, ctrl_d;
  logic                cvalid_q, cvalid_d;
  logic                ready_q, ready_d;
  logic [P-1:0]        phase_q;
  logic                trig_q;
  logic                frz;
  logic                accept;
  logic signed [P-1:0] err_ext;
  logic signed [P-1:0] prop_eff;
  logic [P:0]          nco_sum;

`ifdef TIMING_LOOP_FREEZE_EN
  assign frz = freeze;
`else
  assign frz = 1'b0;
`endif

  // Sums are formed one bit wide so saturation never sees a wrapped value.
  function automatic logic signed [P-1:0] sat_add(
    input logic signed [P-1:0] a,
    input logic signed [P-1:0] b
  );
    logic signed [P:0] s;
    s = $signed({a[P-1], a}) + $signed({b[P-1], b});
    if (s > LIM_HI_W)
      return LIM_HI;
    else if (s < LIM_LO_W)
      return LIM_LO;
    else
      return s[P-1:0];
  endfunction

  assign accept   = error_valid && ready_q;
  assign err_ext  = {{(P-E){err_q[E-1]}}, err_q};
  assign prop_eff = frz ? '0 : prop_q;

  always_comb begin
    state_d  = state_q;
    ready_d  = 1'b0;
    err_d    = err_q;
    prop_d   = prop_q;
    inc_d    = inc_q;
    integ_d  = integ_q;
    ctrl_d   = ctrl_q;
    cvalid_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          err_d   = error;
          state_d = SCALE;
        end else begin
          ready_d = 1'b1;
        end
      end
      SCALE: begin
        prop_d  = err_ext >>> KpShift;
        inc_d   = err_ext >>> KiShift;
        state_d = UPDATE;
      end
      UPDATE: begin
        integ_d  = frz ? integ_q : sat_add(integ_q, inc_q);
        ctrl_d   = sat_add(prop_eff, integ_d);
        cvalid_d = 1'b1;
        ready_d  = 1'b1;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      err_q    <= '0;
      prop_q   <= '0;
      inc_q    <= '0;
      integ_q  <= '0;
      ctrl_q   <= '0;
      cvalid_q <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      err_q    <= err_d;
      prop_q   <= prop_d;
      inc_q    <= inc_d;
      integ_q  <= integ_d;
      ctrl_q   <= ctrl_d;
      cvalid_q <= cvalid_d;
      ready_q  <= ready_d;
    end
  end

  // Step stays in [NOM/2, 3*NOM/2), so the unsigned P+1 sum cannot overflow.
  assign nco_sum = {1'b0, phase_q} + {1'b0, NOM}
                 + {ctrl_q[P-1], ctrl_q};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_q <= '0;
      trig_q  <= 1'b0;
    end else if (sample_strobe) begin
      phase_q <= nco_sum[P-1:0];
      trig_q  <= nco_sum[P];
    end else begin
      trig_q  <= 1'b0;
    end
  end

  assign error_ready   = ready_q;
  assign trigger       = trig_q;
  assign control       = ctrl_q;
  assign control_valid = cvalid_q;

endmodule

// File: tb/tb_timing_loop_nco.sv
// Directed bench for timing_loop_nco: reset, NCO rates, PI filter,
// saturation (KiShift=0 instance), handshake throughput, mid-flight reset.
module tb_timing_loop_nco;

  logic clk = 1'b0;
  logic rst;

  logic signed [24:0] error, e2;
  logic               error_valid, ev2;
  logic               error_ready, er2;
  logic               sample_strobe, ss2;
  logic               trigger, tr2;
  logic signed [31:0] control, c2;
  logic               control_valid, cv2;
`ifdef TIMING_LOOP_FREEZE_EN
  logic               freeze, freeze2;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  timing_loop_nco dut (
    .clk           (clk),
    .rst           (rst),
`ifdef TIMING_LOOP_FREEZE_EN
    .freeze        (freeze),
`endif
    .error         (error),
    .error_valid   (error_valid),
    .error_ready   (error_ready),
    .sample_strobe (sample_strobe),
    .trigger       (trigger),
    .control       (control),
    .control_valid (control_valid)
  );

  timing_loop_nco #(.KiShift(0)) dut2 (
    .clk           (clk),
    .rst           (rst),
`ifdef TIMING_LOOP_FREEZE_EN
    .freeze        (freeze2),
`endif
    .error         (e2),
    .error_valid   (ev2),
    .error_ready   (er2),
    .sample_strobe (ss2),
    .trigger       (tr2),
    .control       (c2),
    .control_valid (cv2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic signed [24:0] v,
                      output logic signed [31:0] ctl,
                      output logic early, output logic cv,
                      output logic ok);
    for (int n = 0; n < 8 && !error_ready; n++) tick();
    ok = error_ready;
    ctl = '0; early = 1'b0; cv = 1'b0;
    if (!ok) return;
    error = v;
    error_valid = 1'b1;
    tick();
    error_valid = 1'b0;
    tick();
    early = control_valid;
    tick();
    ctl = control;
    cv = control_valid;
  endtask

  task automatic push2(input logic signed [24:0] v,
                       output logic signed [31:0] ctl,
                       output logic ok);
    for (int n = 0; n < 8 && !er2; n++) tick();
    ok = er2;
    ctl = '0;
    if (!ok) return;
    e2 = v;
    ev2 = 1'b1;
    tick();
    ev2 = 1'b0;
    tick();
    tick();
    ctl = c2;
  endtask

  task automatic test_reset();
    int bad;
    bad = 0;
    rst = 1'b0;
    error = '0; error_valid = 1'b1; sample_strobe = 1'b1;
    e2 = '0; ev2 = 1'b1; ss2 = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (trigger !== 1'b0 || control !== 32'sd0 ||
          control_valid !== 1'b0 || error_ready !== 1'b0 ||
          tr2 !== 1'b0 || cv2 !== 1'b0 || er2 !== 1'b0)
        bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL reset_outputs: got %0d bad cycles expected 0", bad);
    end
    error_valid = 1'b0; sample_strobe = 1'b0;
    ev2 = 1'b0; ss2 = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if (error_ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_before_edge: got %b expected 0", error_ready);
    end
    tick();
    checks++;
    if (error_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_release: got %b expected 1", error_ready);
    end
  endtask

  task automatic test_free_run();
    int first, last, cnt, bad, nz;
    first = -1; last = 0; cnt = 0; bad = 0; nz = 0;
    sample_strobe = 1'b1;
    for (int k = 1; k <= 400; k++) begin
      tick();
      if (control !== 32'sd0) nz++;
      if (trigger === 1'b1) begin
        if (first < 0) first = k;
        else if (k - last != 4) bad++;
        last = k;
        cnt++;
      end
    end
    sample_strobe = 1'b0;
    checks++;
    if (first !== 4) begin
      errors++;
      $display("FAIL free_first_trigger: got %0d expected 4", first);
    end
    checks++;
    if (cnt !== 100) begin
      errors++;
      $display("FAIL free_trigger_count: got %0d expected 100", cnt);
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL free_interval: got %0d bad expected 0", bad);
    end
    checks++;
    if (nz !== 0) begin
      errors++;
      $display("FAIL free_control_zero: got %0d nonzero expected 0", nz);
    end
    tick();
    checks++;
    if (trigger !== 1'b0) begin
      errors++;
      $display("FAIL no_strobe_trigger: got %b expected 0", trigger);
    end
  endtask

  task automatic test_half_rate();
    int first, last, cnt, bad, wide;
    logic prev;
    first = -1; last = 0; cnt = 0; bad = 0; wide = 0; prev = 1'b0;
    for (int k = 1; k <= 200; k++) begin
      sample_strobe = (k % 2 == 1);
      tick();
      if (trigger === 1'b1) begin
        if (prev) wide++;
        if (first < 0) first = k;
        else if (k - last != 8) bad++;
        last = k;
        cnt++;
      end
      prev = trigger;
    end
    sample_strobe = 1'b0;
    checks++;
    if (first !== 7) begin
      errors++;
      $display("FAIL half_first_trigger: got %0d expected 7", first);
    end
    checks++;
    if (cnt !== 25) begin
      errors++;
      $display("FAIL half_trigger_count: got %0d expected 25", cnt);
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL half_interval: got %0d bad expected 0", bad);
    end
    checks++;
    if (wide !== 0) begin
      errors++;
      $display("FAIL half_pulse_width: got %0d wide expected 0", wide);
    end
  endtask

  task automatic test_filter();
    logic signed [24:0] vin [4];
    logic signed [31:0] vexp [4];
    logic signed [31:0] ctl;
    logic early, cv, ok;
    vin[0] = 25'sd65536;  vexp[0] = 32'sd257;
    vin[1] = 25'sd0;      vexp[1] = 32'sd1;
    vin[2] = -25'sd65536; vexp[2] = -32'sd256;
    vin[3] = -25'sd1;     vexp[3] = -32'sd2;
    for (int i = 0; i < 4; i++) begin
      push(vin[i], ctl, early, cv, ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL filter_ready_timeout[%0d]: got 0 expected 1", i);
      end
      checks++;
      if (early !== 1'b0 || cv !== 1'b1) begin
        errors++;
        $display("FAIL filter_latency[%0d]: got %b%b expected 01",
                 i, early, cv);
      end
      checks++;
      if (ctl !== vexp[i]) begin
        errors++;
        $display("FAIL filter_control[%0d]: got %0d expected %0d",
                 i, ctl, vexp[i]);
      end
    end
    tick();
    checks++;
    if (control_valid !== 1'b0) begin
      errors++;
      $display("FAIL cvalid_width: got %b expected 0", control_valid);
    end
  endtask

  task automatic test_saturation();
    logic signed [31:0] ctl, c31;
    logic ok;
    int to, oob, first, last, bad, cnt;
    to = 0; oob = 0; c31 = '0;
    ss2 = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      push2(25'sd16777215, ctl, ok);
      if (!ok) to++;
      if (ctl < 0 || ctl > 32'sd536870911) oob++;
      if (i == 31) c31 = ctl;
    end
    checks++;
    if (to !== 0) begin
      errors++;
      $display("FAIL sat_ready_timeout: got %0d expected 0", to);
    end
    checks++;
    if (oob !== 0) begin
      errors++;
      $display("FAIL sat_range: got %0d out of range expected 0", oob);
    end
    checks++;
    if (c31 !== 32'sd520159200) begin
      errors++;
      $display("FAIL sat_pre_limit: got %0d expected 520159200", c31);
    end
    checks++;
    if (c2 !== 32'sd536870911) begin
      errors++;
      $display("FAIL sat_control: got %0d expected 536870911", c2);
    end
    first = -1; last = 0; bad = 0; cnt = 0;
    for (int k = 1; k <= 60; k++) begin
      tick();
      if (tr2 === 1'b1) begin
        if (first < 0) first = k;
        else if (k - last < 2 || k - last > 3) bad++;
        last = k;
        cnt++;
      end
    end
    ss2 = 1'b0;
    checks++;
    if (bad !== 0 || cnt < 20) begin
      errors++;
      $display("FAIL sat_trigger_interval: got %0d bad, %0d pulses expected 0, >=20",
               bad, cnt);
    end
  endtask

  task automatic test_back_to_back();
    int acc, rdy;
    acc = 0; rdy = 0;
    error = '0;
    error_valid = 1'b1;
    for (int k = 0; k < 30; k++) begin
      if (error_ready) rdy++;
      if (error_ready && error_valid) acc++;
      tick();
    end
    error_valid = 1'b0;
    tick();
    checks++;
    if (acc !== 10) begin
      errors++;
      $display("FAIL b2b_accepts: got %0d expected 10", acc);
    end
    checks++;
    if (rdy !== 10) begin
      errors++;
      $display("FAIL b2b_ready_cycles: got %0d expected 10", rdy);
    end
    checks++;
    if (control !== -32'sd1) begin
      errors++;
      $display("FAIL b2b_control: got %0d expected -1", control);
    end
  endtask

`ifdef TIMING_LOOP_FREEZE_EN
  task automatic test_freeze();
    logic signed [31:0] ctl;
    logic early, cv, ok;
    freeze = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push(25'sd65536, ctl, early, cv, ok);
      checks++;
      if (!ok || ctl !== -32'sd1) begin
        errors++;
        $display("FAIL freeze_hold[%0d]: got %0d expected -1", i, ctl);
      end
    end
    freeze = 1'b0;
    push(25'sd65536, ctl, early, cv, ok);
    checks++;
    if (!ok || ctl !== 32'sd256) begin
      errors++;
      $display("FAIL freeze_resume: got %0d expected 256", ctl);
    end
  endtask
`endif

  task automatic test_mid_reset();
    int bad;
    bad = 0;
    for (int n = 0; n < 8 && !error_ready; n++) tick();
    error = 25'sd65536;
    error_valid = 1'b1;
    tick();
    error_valid = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (control !== 32'sd0 || control_valid !== 1'b0 ||
        error_ready !== 1'b0) begin
      errors++;
      $display("FAIL midrst_clear: got ctl %0d cv %b rdy %b expected 0 0 0",
               control, control_valid, error_ready);
    end
    sample_strobe = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (control_valid !== 1'b0 || trigger !== 1'b0) bad++;
    end
    sample_strobe = 1'b0;
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL midrst_no_pulse: got %0d bad expected 0", bad);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (error_ready !== 1'b1 || control !== 32'sd0) begin
      errors++;
      $display("FAIL midrst_restart: got rdy %b ctl %0d expected 1 0",
               error_ready, control);
    end
  endtask

  initial begin
`ifdef TIMING_LOOP_FREEZE_EN
    freeze = 1'b0;
    freeze2 = 1'b0;
`endif
    test_reset();
    test_free_run();
    test_half_rate();
    test_filter();
    test_saturation();
    test_back_to_back();
`ifdef TIMING_LOOP_FREEZE_EN
    test_freeze();
`endif
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/timing_loop_nco.md
Name: timing_loop_nco

Overview:
Downstream stage of gardner_ted_pam. It consumes the Gardner timing-error stream and runs it through a proportional-integral (PI) loop filter. It then steers a phase-accumulator NCO that produces the one-cycle `trigger` strobe fed back into gardner_ted_pam and the symbol decimator. Together with the TED, this closes the symbol-timing recovery loop.

Parameters:
SamplesPerSymbol, 4, nominal input samples per symbol; power of two, ≥2
ErrorLengthBits, 25, width of signed timing-error input
PhaseLengthBits, 32, NCO phase-accumulator width; also control/integrator width
KpShift, 8, proportional gain = 2^-KpShift (arithmetic right shift)
KiShift, 16, integral gain = 2^-KiShift (arithmetic right shift)

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-low (0 = in reset)
error  input  ErrorLengthBits  signed timing error from gardner_ted_pam
error_valid  input  1  error word valid
error_ready  output  1  block can accept error this cycle
sample_strobe  input  1  one input sample consumed this cycle; advances NCO
trigger  output  1  one-cycle strobe, once per recovered symbol
control  output  PhaseLengthBits  signed filtered control word (NCO step offset)
control_valid  output  1  one-cycle pulse when control updates

Behaviour:
- Reset (rst low, async): phase=0, integ=0, control=0, trigger=0, control_valid=0, state=IDLE, error_ready=0. error_ready=1 on first cycle after rst deasserts.
- Constants:
  - NOM = 2^PhaseLengthBits / SamplesPerSymbol (2^30 at defaults).
  - LIM_HI = NOM/2-1; LIM_LO = -NOM/2.
- FSM IDLE -> SCALE -> UPDATE -> IDLE, unconditional except IDLE.
  - IDLE: error_ready=1. On error_valid&&error_ready, register error and go to SCALE.
  - SCALE: error_ready=0. Register prop = error>>>KpShift and inc = error>>>KiShift, both sign-extended to PhaseLengthBits.
  - UPDATE: error_ready=0. integ <= sat(integ+inc, LIM_LO, LIM_HI). control <= sat(prop+integ_new, LIM_LO, LIM_HI). control_valid=1 the cycle after the UPDATE edge; return to IDLE.
- Latency: control visible 3 edges after the acceptance edge. Max accept rate is 1 per 3 cycles. error_valid held high with ready low is not consumed.
- Sums are computed one bit wider before saturation, so there is no wrap anywhere in the filter.
- NCO:
  - On sample_strobe: {carry, phase} <= phase + NOM + control, using control as registered before the edge.
  - Step is always in [NOM/2, 3·NOM/2) > 0.
  - trigger=1 for exactly the one cycle after a strobe edge that produced carry; 0 otherwise.
  - No strobe: phase holds and trigger=0.
- Simultaneous events:
  - A control update and a strobe on the same edge: the NCO uses the old control; the new control applies from the next strobe.
  - sample_strobe during any FSM state is always honoured; the NCO never stalls.
- Reset mid-operation discards any in-flight error. No trigger or control_valid is produced after rst falls.

Optional Feature:
Macro TIMING_LOOP_FREEZE_EN.
- Defined: adds input port `freeze` (1 bit). While freeze=1:
  - Errors are still accepted and handshaken.
  - The UPDATE step holds integ unchanged and forces prop to 0, so control=integ.
  - The NCO runs at the frozen rate.
  - When freeze falls, normal updates resume with the next accepted error.
- Undefined: no `freeze` port; filter always updates.

Test Plan:
1. Hold rst=0 for 20 cycles with error_valid=1, sample_strobe=1 -> trigger=0, control=0, control_valid=0, error_ready=0 throughout. After release, error_ready=1 next cycle.
2. No errors, sample_strobe=1 for 400 cycles after reset -> first trigger the cycle after the 4th strobe, then exactly every 4 cycles (100 pulses). control stays 0.
3. sample_strobe on alternate cycles, no errors -> trigger every 8 cycles, each pulse exactly 1 cycle wide.
4. Defaults, single error=65536 -> control_valid pulse 3 edges later with control=257 (prop 256 + integ 1). Then error=0 -> control=1.
5. KiShift=0, KpShift=8, error=16777215 repeated 40 times -> integ and control saturate at 536870911, never wrap. With strobe every cycle, trigger intervals are 2 or 3 cycles, never 4.
6. error_valid held high for 30 cycles -> exactly 10 acceptances, error_ready high 1 cycle in 3. Repeat with TIMING_LOOP_FREEZE_EN and freeze=1 -> control unchanged from its pre-freeze value.
